sccb_responder: RTL and testbench

SCCB_RESPONDER -- requirements
Module: sccb_responder

---
 rtl/sccb_responder.sv | 171 +++++++++++++++++
 tb/tb_sccb_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_responder.sv
// SCCB slave with a 256x8 register file: filtered SIOC/SIOD decode, 3-phase writes with
// pointer auto-increment, 2-phase reads with ACK/NA continuation, soft reset via reg 0x12.
module sccb_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h21,
  parameter logic [7:0] PID_VAL  = 8'h76,
  parameter logic [7:0] VER_VAL  = 8'h73,
  parameter int         FILT     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sioc_in,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, ADDR, ACK, REG, WDATA, RDATA, RD_NA, WAIT_STOP} state_t;

  state_t          r_state, w_state_nxt, r_ack_next;
  logic [1:0]      r_scl_sync, r_sda_sync;
  logic [FILT-1:0] r_scl_hist, r_sda_hist;
  logic            r_scl, r_sda, r_scl_d, r_sda_d;
  logic [3:0]      r_bitcnt;
  logic [7:0]      r_shift, r_ptr;
  logic            r_oe, r_na;
  logic [7:0]      r_regs [256];
  logic            w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_hit, w_rx_state;
  logic            w_byte_done, w_commit, w_soft_rst, w_abort, w_oe_nxt;
  logic [7:0]      w_byte_in, w_rd_byte;
  logic [2:0]      w_bidx;

  function automatic logic [7:0] f_dflt(input logic [7:0] a);
    case (a)
      8'h0A:   return PID_VAL;
      8'h0B:   return VER_VAL;
      default: return 8'h00;
    endcase
  endfunction

  // A new line level is accepted only after FILT identical synchronized samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= '1;
      r_sda_hist <= '1;
      r_scl      <= 1'b1;
      r_sda      <= 1'b1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], sioc_in};
      r_sda_sync <= {r_sda_sync[0], siod_in};
      r_scl_hist <= FILT'({r_scl_hist, r_scl_sync[1]});
      r_sda_hist <= FILT'({r_sda_hist, r_sda_sync[1]});
      if (&r_scl_hist) r_scl <= 1'b1;
      else if (~|r_scl_hist) r_scl <= 1'b0;
      if (&r_sda_hist) r_sda <= 1'b1;
      else if (~|r_sda_hist) r_sda <= 1'b0;
      r_scl_d    <= r_scl;
      r_sda_d    <= r_sda;
    end
  end

  assign w_scl_rise = r_scl & ~r_scl_d;
  assign w_scl_fall = ~r_scl & r_scl_d;
  assign w_start    = r_scl & r_scl_d & r_sda_d & ~r_sda;
  assign w_stop     = r_scl & r_scl_d & ~r_sda_d & r_sda;
  assign w_byte_in  = {r_shift[6:0], r_sda};
  assign w_addr_hit = (r_shift[7:1] == DEV_ADDR);
  assign w_rd_byte  = r_regs[r_ptr];
  assign w_bidx     = ~r_bitcnt[2:0];
  assign w_soft_rst = (r_ptr == 8'h12) && w_byte_in[7];
  assign siod_oe    = r_oe;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) w_state_nxt = IDLE;
    else if (w_start) w_state_nxt = ADDR;
    else if (w_scl_fall) begin
      unique case (r_state)
        ADDR:       if (r_bitcnt == 4'd8) w_state_nxt = w_addr_hit ? ACK : WAIT_STOP;
        REG, WDATA: if (r_bitcnt == 4'd8) w_state_nxt = ACK;
        ACK:        if (r_bitcnt == 4'd1) w_state_nxt = r_ack_next;
        RDATA:      if (r_bitcnt == 4'd8) w_state_nxt = RD_NA;
        RD_NA:      if (r_bitcnt == 4'd1) w_state_nxt = r_na ? WAIT_STOP : RDATA;
        default:    ;
      endcase
    end
  end

  // The SIOC rise that sets up a STOP is itself counted, so a byte is only
  // partial (abort) once at least two rises have been seen in it.
  always_comb begin
    busy        = (r_state != IDLE);
    w_rx_state  = (r_state == ADDR) || (r_state == REG) || (r_state == WDATA);
    w_byte_done = w_scl_rise && w_rx_state && (r_bitcnt == 4'd7);
    w_commit    = w_byte_done && (r_state == WDATA);
    w_abort     = w_stop && (w_rx_state || r_state == RDATA) && (r_bitcnt >= 4'd2);
    w_oe_nxt    = r_oe;
    if (w_stop || w_start) w_oe_nxt = 1'b0;
    else if (w_scl_fall) begin
      unique case (r_state)
        ADDR:       if (r_bitcnt == 4'd8) w_oe_nxt = w_addr_hit;
        REG, WDATA: if (r_bitcnt == 4'd8) w_oe_nxt = 1'b1;
        ACK:        if (r_bitcnt == 4'd1) w_oe_nxt = (r_ack_next == RDATA) ? ~w_rd_byte[7] : 1'b0;
        RDATA:      w_oe_nxt = (r_bitcnt == 4'd8) ? 1'b0 : ~w_rd_byte[w_bidx];
        RD_NA:      if (r_bitcnt == 4'd1) w_oe_nxt = r_na ? 1'b0 : ~w_rd_byte[7];
        default:    w_oe_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_oe       <= 1'b0;
      r_na       <= 1'b0;
      r_bitcnt   <= 4'd0;
      r_shift    <= 8'h00;
      r_ptr      <= 8'h00;
      r_ack_next <= IDLE;
      wr_strobe  <= 1'b0;
      wr_addr    <= 8'h00;
      wr_data    <= 8'h00;
      err        <= 1'b0;
    end else begin
      r_oe      <= w_oe_nxt;
      wr_strobe <= w_commit;
      err       <= w_abort;
      if (w_stop || w_start) r_bitcnt <= 4'd0;
      else if (w_scl_rise) begin
        unique case (r_state)
          ADDR, REG, WDATA, RDATA: begin
            r_shift <= w_byte_in;
            if (r_bitcnt != 4'd8) r_bitcnt <= r_bitcnt + 4'd1;
          end
          ACK:     r_bitcnt <= 4'd1;
          RD_NA: begin
            r_bitcnt <= 4'd1;
            r_na     <= r_sda;
          end
          default: ;
        endcase
      end else if (w_scl_fall && w_state_nxt != r_state) r_bitcnt <= 4'd0;
      if (w_scl_fall && w_rx_state && r_bitcnt == 4'd8)
        r_ack_next <= (r_state != ADDR) ? WDATA : (r_shift[0] ? RDATA : REG);
      if (w_byte_done && r_state == REG) r_ptr <= w_byte_in;
      if (w_commit) begin
        r_ptr   <= r_ptr + 8'd1;
        wr_addr <= r_ptr;
        wr_data <= w_byte_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (w_commit && w_soft_rst)) begin
      for (int i = 0; i < 256; i++) r_regs[i] <= f_dflt(8'(i));
    end else if (w_commit && r_ptr != 8'h0A && r_ptr != 8'h0B) begin
      r_regs[r_ptr] <= w_byte_in;
    end
  end
endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: bit-banged SCCB master on an open-drain SIOD,
// table of write/read-back vectors plus hand sequences for abort, mismatch and glitch cases.
module tb_sccb_responder;
  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  logic       siod_in;
  logic       siod_oe, wr_strobe, busy, err;
  logic [7:0] wr_addr, wr_data;

  int n_chk = 0, n_pass = 0;
  int err_cyc = 0;
  logic busy_seen = 1'b0, oe_seen = 1'b0;
  logic [15:0] st_q [$];

  always #5 clk = ~clk;
  assign siod_in = m_sda & ~siod_oe;

  sccb_responder dut (
    .clk(clk), .rst(rst), .sioc_in(m_scl), .siod_in(siod_in), .siod_oe(siod_oe),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .err(err)
  );

  always @(negedge clk) begin
    if (wr_strobe) st_q.push_back({wr_addr, wr_data});
    if (err) err_cyc++;
    if (busy) busy_seen = 1'b1;
    if (siod_oe) oe_seen = 1'b1;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic wait_q;
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic start_c;
    m_sda = 1'b1; m_scl = 1'b1; wait_q;
    m_sda = 1'b0; wait_q;
    m_scl = 1'b0; wait_q;
  endtask

  task automatic stop_c;
    m_sda = 1'b0; wait_q;
    m_scl = 1'b1; wait_q;
    m_sda = 1'b1; wait_q; wait_q;
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; wait_q;
    m_scl = 1'b1; wait_q; wait_q;
    m_scl = 1'b0; wait_q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; wait_q;
    m_scl = 1'b1; wait_q;
    ack = siod_in; wait_q;
    m_scl = 1'b0; wait_q;
  endtask

  task automatic read_byte(input logic na, output logic [7:0] d, output logic oe9);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; wait_q;
      m_scl = 1'b1; wait_q;
      d[i] = siod_in; wait_q;
      m_scl = 1'b0; wait_q;
    end
    m_sda = na; wait_q;
    m_scl = 1'b1; wait_q;
    oe9 = siod_oe; wait_q;
    m_scl = 1'b0; wait_q;
  endtask

  task automatic wr_reg(input logic [7:0] ra, input logic [7:0] wd);
    logic a;
    start_c;
    send_byte(8'h42, a); chk("wr_dev_ack", 16'(a), 16'h0);
    send_byte(ra, a);    chk("wr_reg_ack", 16'(a), 16'h0);
    send_byte(wd, a);    chk("wr_dat_ack", 16'(a), 16'h0);
    stop_c;
  endtask

  task automatic set_ptr(input logic [7:0] ra);
    logic a;
    start_c;
    send_byte(8'h42, a); chk("ptr_dev_ack", 16'(a), 16'h0);
    send_byte(ra, a);    chk("ptr_reg_ack", 16'(a), 16'h0);
    stop_c;
  endtask

  task automatic rd_reg(input logic [7:0] ra, output logic [7:0] d);
    logic a, oe9;
    set_ptr(ra);
    start_c;
    send_byte(8'h43, a); chk("rd_dev_ack", 16'(a), 16'h0);
    read_byte(1'b1, d, oe9); chk("rd_oe_9th", 16'(oe9), 16'h0);
    stop_c;
  endtask

  typedef struct packed {
    logic       wr;
    logic [7:0] ra;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  vec_t tv [12];

  initial begin
    logic [7:0] d;
    logic       a, oe9;
    int         n0, e0;

    tv[0]  = '{1'b1, 8'h3A, 8'h04, 8'h04};
    tv[1]  = '{1'b0, 8'h0A, 8'h00, 8'h76};
    tv[2]  = '{1'b0, 8'h0B, 8'h00, 8'h73};
    tv[3]  = '{1'b1, 8'h0A, 8'h55, 8'h76};
    tv[4]  = '{1'b1, 8'h0B, 8'hAA, 8'h73};
    tv[5]  = '{1'b1, 8'h00, 8'hA5, 8'hA5};
    tv[6]  = '{1'b1, 8'h7F, 8'h3C, 8'h3C};
    tv[7]  = '{1'b1, 8'h12, 8'h80, 8'h00};
    tv[8]  = '{1'b0, 8'h3A, 8'h00, 8'h00};
    tv[9]  = '{1'b0, 8'h00, 8'h00, 8'h00};
    tv[10] = '{1'b0, 8'h0B, 8'h00, 8'h73};
    tv[11] = '{1'b0, 8'h7F, 8'h00, 8'h00};

    m_scl = 1'b1; m_sda = 1'b1; rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_oe", 16'(siod_oe), 16'h0);
    chk("rst_strobe", 16'(wr_strobe), 16'h0);
    chk("rst_addr_data", {wr_addr, wr_data}, 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      if (tv[i].wr) begin
        n0 = st_q.size();
        wr_reg(tv[i].ra, tv[i].wd);
        chk("wr_strobe_cnt", 16'(st_q.size() - n0), 16'h1);
        if (st_q.size() > n0) chk("wr_addr_data", st_q[n0], {tv[i].ra, tv[i].wd});
      end
      rd_reg(tv[i].ra, d);
      chk($sformatf("rd_val_%0d", i), 16'(d), 16'(tv[i].exp));
    end

    // non-matching address: never drives SIOD, stays busy until STOP
    n0 = st_q.size();
    oe_seen = 1'b0;
    start_c;
    send_byte(8'h60, a); chk("mis_nack", 16'(a), 16'h1);
    chk("mis_busy_a", 16'(busy), 16'h1);
    send_byte(8'h3A, a); chk("mis_busy_b", 16'(busy), 16'h1);
    stop_c;
    chk("mis_busy_end", 16'(busy), 16'h0);
    chk("mis_oe", 16'(oe_seen), 16'h0);
    chk("mis_strobe", 16'(st_q.size() - n0), 16'h0);

    // pointer wrap 0xFF -> 0x00 during a burst write
    n0 = st_q.size();
    start_c;
    send_byte(8'h42, a); send_byte(8'hFF, a);
    send_byte(8'h11, a); send_byte(8'h22, a); chk("wrap_ack", 16'(a), 16'h0);
    stop_c;
    chk("wrap_cnt", 16'(st_q.size() - n0), 16'h2);
    if (st_q.size() >= n0 + 2) begin
      chk("wrap_st0", st_q[n0], 16'hFF11);
      chk("wrap_st1", st_q[n0 + 1], 16'h0022);
    end
    rd_reg(8'hFF, d); chk("wrap_rd_ff", 16'(d), 16'h11);
    rd_reg(8'h00, d); chk("wrap_rd_00", 16'(d), 16'h22);

    // master ACK continues reading the same pointer
    set_ptr(8'h0A);
    start_c;
    send_byte(8'h43, a);
    read_byte(1'b0, d, oe9); chk("cont_rd0", 16'(d), 16'h76); chk("cont_oe0", 16'(oe9), 16'h0);
    read_byte(1'b1, d, oe9); chk("cont_rd1", 16'(d), 16'h76);
    stop_c;

    // STOP inside the register byte aborts with a single err cycle
    n0 = st_q.size();
    e0 = err_cyc;
    start_c;
    send_byte(8'h42, a);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    stop_c;
    chk("abort_err_cyc", 16'(err_cyc - e0), 16'h1);
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_strobe", 16'(st_q.size() - n0), 16'h0);

    // one-cycle SIOD dip while SIOC high must not look like START
    busy_seen = 1'b0;
    @(posedge clk); #1 m_sda = 1'b0;
    @(posedge clk); #1 m_sda = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("glitch_busy", 16'(busy_seen), 16'h0);

    // reset mid-byte: silent abandon, register file back to defaults
    n0 = st_q.size();
    e0 = err_cyc;
    wr_reg(8'h3A, 8'h5A);
    n0 = st_q.size();
    start_c;
    send_byte(8'h42, a);
    send_byte(8'h3A, a);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_sda = 1'b1; wait_q;
    m_scl = 1'b1; repeat (30) @(posedge clk);
    #1;
    chk("rstmid_busy", 16'(busy), 16'h0);
    chk("rstmid_err", 16'(err_cyc - e0), 16'h0);
    chk("rstmid_strobe", 16'(st_q.size() - n0), 16'h0);
    rd_reg(8'h3A, d); chk("rstmid_rd_3a", 16'(d), 16'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
